// File: rtl/corral_pkg.sv
`default_nettype none
// ============================================================================
//  Module    : corral_pkg
//  Purpose   : Shared types and constants for the Corral game engine:
//              controller state enum, cowboy move direction enum, the
//              direction -> (dy, dx) step table and the LFSR constants used
//              when CORRAL_RANDOM_EN is defined.
//  Revision  : 1.0  initial release
// ============================================================================
package corral_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NEWGAME = 3'd1,
        COWBOY  = 3'd2,
        HORSE   = 3'd3,
        REPORT  = 3'd4
    } state_t;

    // Cowboy move directions; north is y-1, east is x+1
    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_t;

    // 2-bit two's-complement step codes
    localparam logic [1:0] c_STEP_0   = 2'b00;
    localparam logic [1:0] c_STEP_POS = 2'b01;
    localparam logic [1:0] c_STEP_NEG = 2'b11;

    // LFSR: x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form
    localparam logic [7:0] c_LFSR_SEED = 8'hA5;
    localparam logic [7:0] c_LFSR_TAPS = 8'hB8;

    // Direction -> {dy, dx}, each a 2-bit step code
    function automatic logic [3:0] dir_step(input dir_t d);
        logic [3:0] r;
        case (d)
            DIR_N:   r = {c_STEP_NEG, c_STEP_0};
            DIR_NE:  r = {c_STEP_NEG, c_STEP_POS};
            DIR_E:   r = {c_STEP_0,   c_STEP_POS};
            DIR_SE:  r = {c_STEP_POS, c_STEP_POS};
            DIR_S:   r = {c_STEP_POS, c_STEP_0};
            DIR_SW:  r = {c_STEP_POS, c_STEP_NEG};
            DIR_W:   r = {c_STEP_0,   c_STEP_NEG};
            DIR_NW:  r = {c_STEP_NEG, c_STEP_NEG};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & c_LFSR_TAPS)};
    endfunction

endpackage : corral_pkg
`default_nettype wire

// File: rtl/corral_horse_step.sv
`default_nettype none
// ============================================================================
//  Module    : corral_horse_step
//  Purpose   : Combinational single-horse move. Picks the preferred axis
//              (larger distance from the cowboy, x on ties unless i_tie_y),
//              steps away from the cowboy on it, falls back to the other
//              axis, and stays if both are blocked by a wall, an occupied
//              cell or the cowboy.
//  Ports     : i_horse_pos  current horse position {y, x}
//              i_cowboy_pos cowboy position {y, x}
//              i_occ        one bit per cell, set where an uncaptured horse is
//              i_tie_y      on |dx|==|dy|, prefer the y axis
//              i_stay       force the horse to stay this cycle
//              o_next_pos   resulting horse position
//  Revision  : 1.0  initial release
// ============================================================================
module corral_horse_step #(
    parameter int POS_W = 4
) (
    input  logic [POS_W-1:0]      i_horse_pos,
    input  logic [POS_W-1:0]      i_cowboy_pos,
    input  logic [2**POS_W-1:0]   i_occ,
    input  logic                  i_tie_y,
    input  logic                  i_stay,
    output logic [POS_W-1:0]      o_next_pos
);

    localparam int c_HALF = POS_W / 2;

    logic [c_HALF-1:0] w_hx, w_hy, w_cx, w_cy;
    logic [c_HALF+1:0] w_dx, w_dy, w_adx, w_ady;
    logic              w_x_up, w_y_up;
    logic              w_x_wall, w_y_wall;
    logic [c_HALF-1:0] w_x_tgt, w_y_tgt;
    logic [POS_W-1:0]  w_x_cell, w_y_cell;
    logic              w_x_blk, w_y_blk;
    logic              w_prefer_y;

    assign w_hx = i_horse_pos[c_HALF-1:0];
    assign w_hy = i_horse_pos[POS_W-1:c_HALF];
    assign w_cx = i_cowboy_pos[c_HALF-1:0];
    assign w_cy = i_cowboy_pos[POS_W-1:c_HALF];

    // Two extra bits: the top bit is the sign of the difference
    assign w_dx  = {2'b00, w_hx} - {2'b00, w_cx};
    assign w_dy  = {2'b00, w_hy} - {2'b00, w_cy};
    assign w_adx = w_dx[c_HALF+1] ? -w_dx : w_dx;
    assign w_ady = w_dy[c_HALF+1] ? -w_dy : w_dy;

    assign w_prefer_y = (w_ady > w_adx) || ((w_ady == w_adx) && i_tie_y);

    // Flee direction; when aligned, head toward the board's far half
    assign w_x_up = (w_dx == '0) ? ~w_hx[c_HALF-1] : ~w_dx[c_HALF+1];
    assign w_y_up = (w_dy == '0) ? ~w_hy[c_HALF-1] : ~w_dy[c_HALF+1];

    assign w_x_wall = w_x_up ? (w_hx == {c_HALF{1'b1}}) : (w_hx == '0);
    assign w_y_wall = w_y_up ? (w_hy == {c_HALF{1'b1}}) : (w_hy == '0);

    assign w_x_tgt  = w_x_up ? (w_hx + 1'b1) : (w_hx - 1'b1);
    assign w_y_tgt  = w_y_up ? (w_hy + 1'b1) : (w_hy - 1'b1);
    assign w_x_cell = {w_hy, w_x_tgt};
    assign w_y_cell = {w_y_tgt, w_hx};

    // Wall test first: a wrapped target cell is meaningless
    assign w_x_blk = w_x_wall || i_occ[w_x_cell] || (w_x_cell == i_cowboy_pos);
    assign w_y_blk = w_y_wall || i_occ[w_y_cell] || (w_y_cell == i_cowboy_pos);

    always_comb begin
        o_next_pos = i_horse_pos;
        if (!i_stay) begin
            if (w_prefer_y) begin
                if (!w_y_blk)      o_next_pos = w_y_cell;
                else if (!w_x_blk) o_next_pos = w_x_cell;
            end else begin
                if (!w_x_blk)      o_next_pos = w_x_cell;
                else if (!w_y_blk) o_next_pos = w_y_cell;
            end
        end
    end

endmodule : corral_horse_step
`default_nettype wire

// File: rtl/corral_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : corral_game_ctrl
//  Purpose   : Corral game engine. One cowboy chases N_HORSES horses on a
//              2^(POS_W/2)-square board. A turn moves the cowboy, steps each
//              uncaptured horse in index order (one per cycle), then streams
//              the cowboy word followed by every horse word.
//  Ports     : clock, reset (sync, active-high)
//              move[2:0], enter        turn request (accepted when ready)
//              data, data_valid, data_captured   position stream
//              gameover, lostwon, ready, moves_left  game status
//              All outputs are registered.
//  Config    : CORRAL_RANDOM_EN - adds an 8-bit LFSR that breaks axis ties
//              and occasionally freezes a horse for its cycle.
//  Revision  : 1.0  initial release
// ============================================================================
module corral_game_ctrl
    import corral_pkg::*;
#(
    parameter int POS_W     = 4,
    parameter int N_HORSES  = 2,
    parameter int MAX_MOVES = 15,
    localparam int MW       = $clog2(MAX_MOVES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       move,
    input  logic             enter,
    output logic [POS_W-1:0] data,
    output logic             data_valid,
    output logic             data_captured,
    output logic             gameover,
    output logic             lostwon,
    output logic             ready,
    output logic [MW-1:0]    moves_left
);

    localparam int c_HALF = POS_W / 2;
    localparam int c_SIDE = 1 << c_HALF;
    localparam int c_CW   = $clog2(N_HORSES + 1);
    localparam logic [c_HALF-1:0] c_CMAX = {c_HALF{1'b1}};

    state_t              r_state, w_state_nxt;
    logic [c_CW-1:0]     r_cnt, w_cnt_nxt;
    logic [POS_W-1:0]    r_cowboy, w_cowboy_nxt;
    logic [POS_W-1:0]    r_horse [N_HORSES];
    logic [POS_W-1:0]    w_horse_nxt [N_HORSES];
    logic [N_HORSES-1:0] r_capt, w_capt_nxt;
    logic [MW-1:0]       r_moves, w_moves_nxt;
    logic                r_gameover, w_gameover_nxt;
    logic                r_lostwon, w_lostwon_nxt;
    logic                r_ready, w_ready_nxt;
    logic [POS_W-1:0]    r_data, w_data_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_dcapt, w_dcapt_nxt;

    logic                w_accept;
    logic [3:0]          w_dir_step;
    logic [c_HALF-1:0]   w_cx, w_cy, w_cx_new, w_cy_new;
    logic [POS_W-1:0]    w_cowboy_mv;
    logic [N_HORSES-1:0] w_capt_after;
    logic                w_all_capt;
    logic                w_horse_last, w_report_last;
    logic [POS_W-1:0]    w_sel_pos;
    logic [2**POS_W-1:0] w_occ;
    logic [POS_W-1:0]    w_step_pos;
    logic                w_tie_y, w_stay;

    assign w_accept      = (r_state == IDLE) && r_ready && enter;
    assign w_horse_last  = (r_cnt == c_CW'(N_HORSES - 1));
    assign w_report_last = (r_cnt == c_CW'(N_HORSES));

    // ------------------------------------------------------------------
    // Cowboy move: per-axis step, clamped at the walls
    // ------------------------------------------------------------------
    assign w_dir_step = dir_step(dir_t'(move));
    assign w_cx       = r_cowboy[c_HALF-1:0];
    assign w_cy       = r_cowboy[POS_W-1:c_HALF];

    always_comb begin
        w_cx_new = w_cx;
        w_cy_new = w_cy;
        if ((w_dir_step[1:0] == c_STEP_POS) && (w_cx != c_CMAX)) w_cx_new = w_cx + 1'b1;
        if ((w_dir_step[1:0] == c_STEP_NEG) && (w_cx != '0))     w_cx_new = w_cx - 1'b1;
        if ((w_dir_step[3:2] == c_STEP_POS) && (w_cy != c_CMAX)) w_cy_new = w_cy + 1'b1;
        if ((w_dir_step[3:2] == c_STEP_NEG) && (w_cy != '0))     w_cy_new = w_cy - 1'b1;
    end

    assign w_cowboy_mv = {w_cy_new, w_cx_new};

    // Capture every uncaptured horse standing on the cowboy's new cell
    always_comb begin
        w_capt_after = r_capt;
        for (int i = 0; i < N_HORSES; i++) begin
            if (r_horse[i] == w_cowboy_mv) w_capt_after[i] = 1'b1;
        end
    end

    assign w_all_capt = &w_capt_after;

    // ------------------------------------------------------------------
    // Horse stepper, shared across horses by r_cnt
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_pos = r_horse[0];
        w_occ     = '0;
        for (int i = 0; i < N_HORSES; i++) begin
            if (r_cnt == c_CW'(i)) w_sel_pos = r_horse[i];
            if (!r_capt[i])        w_occ[r_horse[i]] = 1'b1;
        end
    end

`ifdef CORRAL_RANDOM_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clock) begin
        if (reset) r_lfsr <= c_LFSR_SEED;
        else       r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_tie_y = r_lfsr[0];
    assign w_stay  = (r_lfsr[7:5] == 3'b000);
`else
    assign w_tie_y = 1'b0;
    assign w_stay  = 1'b0;
`endif

    corral_horse_step #(
        .POS_W        (POS_W)
    ) u_horse_step (
        .i_horse_pos  (w_sel_pos),
        .i_cowboy_pos (r_cowboy),
        .i_occ        (w_occ),
        .i_tie_y      (w_tie_y),
        .i_stay       (w_stay),
        .o_next_pos   (w_step_pos)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = r_gameover ? NEWGAME : COWBOY;
            NEWGAME: w_state_nxt = REPORT;
            COWBOY:  w_state_nxt = w_all_capt ? REPORT : HORSE;
            HORSE:   if (w_horse_last)  w_state_nxt = REPORT;
            REPORT:  if (w_report_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and game datapath (next values, registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_cowboy_nxt   = r_cowboy;
        w_horse_nxt    = r_horse;
        w_capt_nxt     = r_capt;
        w_moves_nxt    = r_moves;
        w_gameover_nxt = r_gameover;
        w_lostwon_nxt  = r_lostwon;
        w_ready_nxt    = 1'b0;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_dcapt_nxt    = r_dcapt;
        case (r_state)
            IDLE: begin
                // Only IDLE with no accepted request keeps ready high
                w_ready_nxt = ~w_accept;
                w_cnt_nxt   = '0;
            end
            NEWGAME: begin
                w_cowboy_nxt = '0;
                for (int i = 0; i < N_HORSES; i++) begin
                    w_horse_nxt[i] = {c_HALF'(c_SIDE - 1 - i), c_CMAX};
                end
                w_capt_nxt     = '0;
                w_moves_nxt    = MW'(MAX_MOVES);
                w_gameover_nxt = 1'b0;
                w_lostwon_nxt  = 1'b0;
                w_cnt_nxt      = '0;
            end
            COWBOY: begin
                w_cowboy_nxt = w_cowboy_mv;
                w_capt_nxt   = w_capt_after;
                if (r_moves != '0) w_moves_nxt = r_moves - 1'b1;
                if (w_all_capt) begin
                    w_gameover_nxt = 1'b1;
                    w_lostwon_nxt  = 1'b1;
                end
                w_cnt_nxt = '0;
            end
            HORSE: begin
                for (int i = 0; i < N_HORSES; i++) begin
                    if ((r_cnt == c_CW'(i)) && !r_capt[i]) w_horse_nxt[i] = w_step_pos;
                end
                if (w_horse_last) begin
                    w_cnt_nxt = '0;
                    if ((r_moves == '0) && !(&r_capt)) begin
                        w_gameover_nxt = 1'b1;
                        w_lostwon_nxt  = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            REPORT: begin
                w_valid_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_data_nxt  = r_cowboy;
                    w_dcapt_nxt = 1'b0;
                end
                for (int i = 0; i < N_HORSES; i++) begin
                    if (r_cnt == c_CW'(i + 1)) begin
                        w_data_nxt  = r_horse[i];
                        w_dcapt_nxt = r_capt[i];
                    end
                end
                w_cnt_nxt = w_report_last ? '0 : r_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_cowboy   <= '0;
            for (int i = 0; i < N_HORSES; i++) r_horse[i] <= '0;
            r_capt     <= '0;
            r_moves    <= '0;
            r_gameover <= 1'b1;
            r_lostwon  <= 1'b0;
            r_ready    <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_dcapt    <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_cowboy   <= w_cowboy_nxt;
            r_horse    <= w_horse_nxt;
            r_capt     <= w_capt_nxt;
            r_moves    <= w_moves_nxt;
            r_gameover <= w_gameover_nxt;
            r_lostwon  <= w_lostwon_nxt;
            r_ready    <= w_ready_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_dcapt    <= w_dcapt_nxt;
        end
    end

    assign data          = r_data;
    assign data_valid    = r_valid;
    assign data_captured = r_dcapt;
    assign gameover      = r_gameover;
    assign lostwon       = r_lostwon;
    assign ready         = r_ready;
    assign moves_left    = r_moves;

endmodule : corral_game_ctrl
`default_nettype wire

// File: tb/tb_corral_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_corral_game_ctrl
//  Purpose   : Self-checking bench for corral_game_ctrl (POS_W=4, N_HORSES=2,
//              MAX_MOVES=15). A board-level game model predicts each turn's
//              stream, latency and status; a monitor compares every streamed
//              word against it, and directed literals pin key results.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_corral_game_ctrl;

    localparam int POS_W = 4;
    localparam int NH    = 2;
    localparam int MAXM  = 15;
    localparam int SIDE  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] move  = 3'd0;
    logic       enter = 1'b0;
    logic [3:0] data;
    logic       data_valid, data_captured, gameover, lostwon, ready;
    logic [3:0] moves_left;

    corral_game_ctrl #(
        .POS_W         (POS_W),
        .N_HORSES      (NH),
        .MAX_MOVES     (MAXM)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .move          (move),
        .enter         (enter),
        .data          (data),
        .data_valid    (data_valid),
        .data_captured (data_captured),
        .gameover      (gameover),
        .lostwon       (lostwon),
        .ready         (ready),
        .moves_left    (moves_left)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---------------- game model ----------------
    int mcx, mcy;
    int mhx [NH];
    int mhy [NH];
    bit mcap [NH];
    int mmoves = 0;
    bit mgo    = 1'b1;
    bit mlw    = 1'b0;

    int exp_word [$];
    int exp_cap  [$];
    int exp_cyc  [$];
    int exp_idx  [$];
    int last_word [NH+1];
    int last_cap  [NH+1];

    function automatic int clampc(input int v);
        if (v < 0) return 0;
        if (v > SIDE - 1) return SIDE - 1;
        return v;
    endfunction

    function automatic bit cell_blocked(input int y, input int x);
        if (x < 0 || x >= SIDE || y < 0 || y >= SIDE) return 1'b1;
        if (y == mcy && x == mcx) return 1'b1;
        for (int j = 0; j < NH; j++)
            if (!mcap[j] && mhy[j] == y && mhx[j] == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int flee(input int d, input int c);
        if (d > 0) return 1;
        if (d < 0) return -1;
        return (c < SIDE / 2) ? 1 : -1;
    endfunction

    task automatic model_horse(input int i);
        int dx, dy, adx, ady, ny, nx;
        bit x_first, moved;
        dx = mhx[i] - mcx;
        dy = mhy[i] - mcy;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        x_first = (adx >= ady);
        moved = 1'b0;
        for (int a = 0; a < 2; a++) begin
            bit use_x;
            use_x = (a == 0) ? x_first : !x_first;
            ny = mhy[i];
            nx = mhx[i];
            if (use_x) nx = mhx[i] + flee(dx, mhx[i]);
            else       ny = mhy[i] + flee(dy, mhy[i]);
            if (!moved && !cell_blocked(ny, nx)) begin
                mhx[i] = nx;
                mhy[i] = ny;
                moved = 1'b1;
            end
        end
    endtask

    task automatic model_turn(input int mv, input int t, output int rdy);
        int first, ddx, ddy;
        bit all;
        if (mgo) begin
            mcx = 0; mcy = 0;
            for (int i = 0; i < NH; i++) begin
                mhx[i] = SIDE - 1; mhy[i] = SIDE - 1 - i; mcap[i] = 1'b0;
            end
            mmoves = MAXM; mgo = 1'b0; mlw = 1'b0;
            first = t + 2; rdy = t + 3 + NH;
        end else begin
            case (mv)
                0: begin ddy = -1; ddx =  0; end
                1: begin ddy = -1; ddx =  1; end
                2: begin ddy =  0; ddx =  1; end
                3: begin ddy =  1; ddx =  1; end
                4: begin ddy =  1; ddx =  0; end
                5: begin ddy =  1; ddx = -1; end
                6: begin ddy =  0; ddx = -1; end
                default: begin ddy = -1; ddx = -1; end
            endcase
            mcx = clampc(mcx + ddx);
            mcy = clampc(mcy + ddy);
            if (mmoves > 0) mmoves--;
            all = 1'b1;
            for (int i = 0; i < NH; i++) begin
                if (mhx[i] == mcx && mhy[i] == mcy) mcap[i] = 1'b1;
                if (!mcap[i]) all = 1'b0;
            end
            if (all) begin
                mgo = 1'b1; mlw = 1'b1;
                first = t + 2; rdy = t + 3 + NH;
            end else begin
                for (int i = 0; i < NH; i++) if (!mcap[i]) model_horse(i);
                if (mmoves == 0) begin mgo = 1'b1; mlw = 1'b0; end
                first = t + 2 + NH; rdy = t + 3 + 2 * NH;
            end
        end
        exp_word.push_back(mcy * SIDE + mcx); exp_cap.push_back(0);
        exp_cyc.push_back(first); exp_idx.push_back(0);
        for (int i = 0; i < NH; i++) begin
            exp_word.push_back(mhy[i] * SIDE + mhx[i]); exp_cap.push_back(int'(mcap[i]));
            exp_cyc.push_back(first + 1 + i); exp_idx.push_back(i + 1);
        end
    endtask

    // ---------------- stream monitor ----------------
    always @(negedge clock) begin
        if (exp_cyc.size() > 0 && !data_valid && cyc > exp_cyc[0]) begin
            chk("missing_word", 0, exp_word[0]);
            void'(exp_word.pop_front()); void'(exp_cap.pop_front());
            void'(exp_cyc.pop_front());  void'(exp_idx.pop_front());
        end
        if (data_valid) begin
            if (exp_word.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                int w, c, t, k;
                w = exp_word.pop_front(); c = exp_cap.pop_front();
                t = exp_cyc.pop_front();  k = exp_idx.pop_front();
                chk("stream_word", int'(data), w);
                chk("stream_captured", int'(data_captured), c);
                chk("stream_cycle", cyc, t);
                last_word[k] = int'(data);
                last_cap[k]  = int'(data_captured);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic accept_turn(input int mv, output int t, output int rdy);
        wait_ready();
        move  = mv[2:0];
        enter = 1'b1;
        @(posedge clock);
        #1;
        enter = 1'b0;
        t = cyc;
        chk("ready_drop", int'(ready), 0);
        model_turn(mv, t, rdy);
    endtask

    task automatic finish_turn(input int t, input int rdy, input bit poke);
        int k = 0;
        @(negedge clock);
        while (k < 200) begin
            if (poke) enter = (cyc >= t + 2 + NH) && !ready;
            if (ready) break;
            @(negedge clock);
            k++;
        end
        enter = 1'b0;
        chk("ready_cycle", cyc, rdy);
        chk("stream_drained", exp_word.size(), 0);
        chk("gameover", int'(gameover), int'(mgo));
        chk("lostwon", int'(lostwon), int'(mlw));
        chk("moves_left", int'(moves_left), mmoves);
    endtask

    task automatic turn(input int mv, input bit poke);
        int t, rdy;
        accept_turn(mv, t, rdy);
        finish_turn(t, rdy, poke);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_data"}, int'(data), 0);
        chk({tag, "_valid"}, int'(data_valid), 0);
        chk({tag, "_captured"}, int'(data_captured), 0);
        chk({tag, "_gameover"}, int'(gameover), 1);
        chk({tag, "_lostwon"}, int'(lostwon), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_moves"}, int'(moves_left), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, rdy;

        // Reset and first ready
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_values("rst");
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("ready_after_reset", int'(ready), 1);

        // New game
        turn(0, 1'b0);
        chk("ng_cowboy", last_word[0], 0);
        chk("ng_h0", last_word[1], 15);
        chk("ng_h1", last_word[2], 11);
        chk("ng_moves", int'(moves_left), 15);

        // East: both horses boxed in
        turn(2, 1'b0);
        chk("e_cowboy", last_word[0], 1);
        chk("e_h0", last_word[1], 15);
        chk("e_h1", last_word[2], 11);
        chk("e_moves", int'(moves_left), 14);

        // Back to the corner, then push into walls
        turn(6, 1'b0);
        turn(0, 1'b0);
        chk("n_wall_cowboy", last_word[0], 0);
        chk("n_wall_moves", int'(moves_left), 12);
        turn(7, 1'b0);
        chk("nw_wall_cowboy", last_word[0], 0);
        chk("nw_wall_moves", int'(moves_left), 11);

        // Chase down both horses
        turn(3, 1'b0);
        turn(3, 1'b0);
        turn(3, 1'b0);
        chk("first_capture", last_cap[1], 1);
        turn(0, 1'b0);
        turn(7, 1'b0);
        turn(7, 1'b0);
        chk("win_cowboy", last_word[0], 1);
        chk("win_h0", last_word[1], 15);
        chk("win_h1", last_word[2], 1);
        chk("win_cap0", last_cap[1], 1);
        chk("win_cap1", last_cap[2], 1);
        chk("win_gameover", int'(gameover), 1);
        chk("win_lostwon", int'(lostwon), 1);
        chk("win_moves", int'(moves_left), 5);

        // Next enter restarts; then burn all moves without a capture
        turn(4, 1'b0);
        chk("restart_moves", int'(moves_left), 15);
        chk("restart_gameover", int'(gameover), 0);
        for (int i = 0; i < 14; i++) turn(0, 1'b0);
        turn(0, 1'b1);
        chk("loss_gameover", int'(gameover), 1);
        chk("loss_lostwon", int'(lostwon), 0);
        chk("loss_moves", int'(moves_left), 0);
        repeat (6) @(negedge clock);
        chk("loss_hold_ready", int'(ready), 1);
        chk("loss_hold_moves", int'(moves_left), 0);

        // Reset in the middle of the horse phase
        turn(0, 1'b0);
        accept_turn(2, t, rdy);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_reset_values("midrst");
        exp_word.delete(); exp_cap.delete(); exp_cyc.delete(); exp_idx.delete();
        mgo = 1'b1; mlw = 1'b0; mmoves = 0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_ready", int'(ready), 1);
        turn(5, 1'b0);
        chk("post_rst_h1", last_word[2], 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_corral_game_ctrl
`default_nettype wire
